// File: rtl/uart_rx_if.sv
// Byte-stream side of the UART receiver: serial line in, received byte and status out.
interface uart_rx_if;
   logic       RX;
   logic       READY;
   logic [7:0] DATA;
   logic       VALID;
   logic       FRAME_ERR;
   logic       OVERRUN;
   logic       BUSY;

   modport master (
      input  RX, READY,
      output DATA, VALID, FRAME_ERR, OVERRUN, BUSY
   );

   modport slave (
      output RX, READY,
      input  DATA, VALID, FRAME_ERR, OVERRUN, BUSY
   );
endinterface

// File: rtl/uart_rx.sv
// 8N1 UART receiver with centre sampling and a one-deep VALID/READY output register.
// Define UART_RX_PARITY_EN to expect an even-parity bit between bit 7 and the stop bit.
//
// state    | meaning
// ---------+------------------------------------------------------------
// S_IDLE   | line idle, waiting for a synchronized 1->0 transition
// S_START  | half a bit time to the middle of the start bit
// S_DATA   | sampling the 8 data bits LSB-first, one per bit time
// S_PARITY | sampling the even-parity bit (parity builds only)
// S_STOP   | sampling the stop bit, then deliver / overrun / frame error
module uart_rx #(
   parameter int unsigned DIVISOR = 103
) (
   input logic       CLK,
   input logic       RESETN,
   uart_rx_if.master bus
);

`ifdef UART_RX_PARITY_EN
   typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;
`else
   typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;
`endif

   localparam logic [7:0] TIMER_FULL = 8'(DIVISOR);
   localparam logic [7:0] TIMER_HALF = 8'(DIVISOR / 2);

   state_t     state, state_nx;
   logic       rx_meta, rx_sync, rx_prev;
   logic [7:0] timer, timer_nx;
   logic [3:0] bit_cnt, bit_cnt_nx;
   logic [7:0] shift, shift_nx;
   logic [7:0] data_q, data_nx;
   logic       valid_q, valid_nx;
   logic       ferr_q, ferr_nx;
   logic       ovr_q, ovr_nx;
   logic       expire;
   logic       start_edge;
   logic       stop_ok;

`ifdef UART_RX_PARITY_EN
   logic par_q, par_nx;
   assign stop_ok = rx_sync && ((^shift) == par_q);
`else
   assign stop_ok = rx_sync;
`endif

   assign expire     = (timer == 8'd1);
   // rx_prev follows rx_sync so a line still low after a bad stop bit never looks like a new edge
   assign start_edge = rx_prev && !rx_sync;

   always_ff @(posedge CLK or negedge RESETN) begin
      if (!RESETN) begin
         rx_meta <= 1'b1;
         rx_sync <= 1'b1;
         rx_prev <= 1'b1;
      end else begin
         rx_meta <= bus.RX;
         rx_sync <= rx_meta;
         rx_prev <= rx_sync;
      end
   end

   always_ff @(posedge CLK or negedge RESETN) begin
      if (!RESETN) state <= S_IDLE;
      else         state <= state_nx;
   end

   always_comb begin
      state_nx   = state;
      timer_nx   = timer;
      bit_cnt_nx = bit_cnt;
      shift_nx   = shift;
      data_nx    = data_q;
      valid_nx   = valid_q;
      ferr_nx    = 1'b0;
      ovr_nx     = 1'b0;
`ifdef UART_RX_PARITY_EN
      par_nx     = par_q;
`endif
      if (valid_q && bus.READY) valid_nx = 1'b0;
      if (state != S_IDLE && !expire) timer_nx = timer - 8'd1;

      case (state)
         S_IDLE: begin
            if (start_edge) begin
               timer_nx = TIMER_HALF;
               state_nx = S_START;
            end
         end
         S_START: begin
            if (expire) begin
               if (!rx_sync) begin
                  timer_nx   = TIMER_FULL;
                  bit_cnt_nx = 4'd0;
                  state_nx   = S_DATA;
               end else begin
                  timer_nx = 8'd0;
                  state_nx = S_IDLE;
               end
            end
         end
         S_DATA: begin
            if (expire) begin
               shift_nx   = {rx_sync, shift[7:1]};
               timer_nx   = TIMER_FULL;
               bit_cnt_nx = bit_cnt + 4'd1;
               if (bit_cnt == 4'd7) begin
`ifdef UART_RX_PARITY_EN
                  state_nx = S_PARITY;
`else
                  state_nx = S_STOP;
`endif
               end
            end
         end
`ifdef UART_RX_PARITY_EN
         S_PARITY: begin
            if (expire) begin
               par_nx   = rx_sync;
               timer_nx = TIMER_FULL;
               state_nx = S_STOP;
            end
         end
`endif
         S_STOP: begin
            if (expire) begin
               timer_nx = 8'd0;
               state_nx = S_IDLE;
               if (stop_ok) begin
                  if (!valid_q || bus.READY) begin
                     data_nx  = shift;
                     valid_nx = 1'b1;
                  end else begin
                     ovr_nx = 1'b1;
                  end
               end else begin
                  ferr_nx = 1'b1;
               end
            end
         end
         default: begin
            timer_nx = 8'd0;
            state_nx = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge CLK or negedge RESETN) begin
      if (!RESETN) begin
         timer   <= 8'd0;
         bit_cnt <= 4'd0;
         shift   <= 8'd0;
         data_q  <= 8'd0;
         valid_q <= 1'b0;
         ferr_q  <= 1'b0;
         ovr_q   <= 1'b0;
      end else begin
         timer   <= timer_nx;
         bit_cnt <= bit_cnt_nx;
         shift   <= shift_nx;
         data_q  <= data_nx;
         valid_q <= valid_nx;
         ferr_q  <= ferr_nx;
         ovr_q   <= ovr_nx;
      end
   end

`ifdef UART_RX_PARITY_EN
   always_ff @(posedge CLK or negedge RESETN) begin
      if (!RESETN) par_q <= 1'b0;
      else         par_q <= par_nx;
   end
`endif

   assign bus.DATA      = data_q;
   assign bus.VALID     = valid_q;
   assign bus.FRAME_ERR = ferr_q;
   assign bus.OVERRUN   = ovr_q;
   assign bus.BUSY      = (state != S_IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: frame-timing reference model compared every cycle, plus literal checks.
module tb_uart_rx;
   localparam int D = 103;
   localparam int H = D / 2;
`ifdef UART_RX_PARITY_EN
   localparam int STOP_AT = H + 10 * D;
`else
   localparam int STOP_AT = H + 9 * D;
`endif

   logic CLK;
   logic RESETN;
   uart_rx_if bus ();

   uart_rx #(.DIVISOR(D)) u_dut (
      .CLK   (CLK),
      .RESETN(RESETN),
      .bus   (bus)
   );

   initial begin
      CLK = 1'b0;
      forever #5 CLK = ~CLK;
   end

   int vectors = 0;
   int miscompares = 0;

   task automatic check(input string name, input logic [11:0] got, input logic [11:0] want);
      vectors++;
      if (got !== want) begin
         miscompares++;
         $display("FAIL %s: got %h, want %h", name, got, want);
      end
   endtask

   // Reference model: sample instants are offsets from the detected start edge
   logic       d1, d2, d3, sy, pv, vold;
   logic       act;
   int         el;
   logic [7:0] bits;
   logic       e_valid, e_ferr, e_ovr, e_busy, e_pok;
   logic [7:0] e_data;
`ifdef UART_RX_PARITY_EN
   logic       par;
`endif

   always @(posedge CLK or negedge RESETN) begin
      if (!RESETN) begin
         d1 = 1'b1; d2 = 1'b1; d3 = 1'b1;
         act = 1'b0; el = 0; bits = 8'h00;
         e_valid = 1'b0; e_ferr = 1'b0; e_ovr = 1'b0; e_busy = 1'b0; e_data = 8'h00;
`ifdef UART_RX_PARITY_EN
         par = 1'b0;
`endif
      end else begin
         sy = d2; pv = d3; vold = e_valid;
         e_ferr = 1'b0; e_ovr = 1'b0;
         if (e_valid && bus.READY) e_valid = 1'b0;
         if (!act) begin
            if (pv && !sy) begin act = 1'b1; el = 0; end
         end else begin
            el++;
            if (el == H) begin
               if (sy) act = 1'b0;
            end else if (el > H && el <= H + 8 * D && (el - H) % D == 0) begin
               bits[(el - H) / D - 1] = sy;
`ifdef UART_RX_PARITY_EN
            end else if (el == H + 9 * D) begin
               par = sy;
`endif
            end else if (el == STOP_AT) begin
               act = 1'b0;
`ifdef UART_RX_PARITY_EN
               e_pok = ((^bits) ^ par) == 1'b0;
`else
               e_pok = 1'b1;
`endif
               if (sy && e_pok) begin
                  if (!vold || bus.READY) begin e_data = bits; e_valid = 1'b1; end
                  else e_ovr = 1'b1;
               end else begin
                  e_ferr = 1'b1;
               end
            end
         end
         e_busy = act;
         d3 = d2; d2 = d1; d1 = bus.RX;
      end
   end

   always @(negedge CLK)
      check("cycle", {bus.BUSY, bus.VALID, bus.FRAME_ERR, bus.OVERRUN, bus.DATA},
                     {e_busy, e_valid, e_ferr, e_ovr, e_data});

   int cyc = 0;
   always @(posedge CLK) cyc++;

   int         rise_cnt = 0, hi_cnt = 0, ferr_cnt = 0, ovr_cnt = 0, rise_cyc = 0;
   logic [7:0] rise_data = 8'h00;
   logic       v_prev = 1'b0;
   always @(negedge CLK) begin
      if (bus.VALID && !v_prev) begin
         rise_cnt++;
         rise_cyc  = cyc;
         rise_data = bus.DATA;
      end
      if (bus.VALID)     hi_cnt++;
      if (bus.FRAME_ERR) ferr_cnt++;
      if (bus.OVERRUN)   ovr_cnt++;
      v_prev = bus.VALID;
   end

   task automatic idle(input int n);
      repeat (n) @(negedge CLK);
   endtask

   task automatic drive_bit(input logic b);
      bus.RX = b;
      idle(D);
   endtask

   task automatic send(input logic [7:0] b, input logic stop, input logic pflip);
      drive_bit(1'b0);
      for (int i = 0; i < 8; i++) drive_bit(b[i]);
`ifdef UART_RX_PARITY_EN
      drive_bit((^b) ^ pflip);
`endif
      drive_bit(stop);
   endtask

   int r0, h0, f0, o0, c0, lat;

   initial begin
      RESETN = 1'b0;
      bus.RX = 1'b1;
      bus.READY = 1'b1;
      idle(4);
      check("reset_outputs", {bus.BUSY, bus.VALID, bus.FRAME_ERR, bus.OVERRUN, bus.DATA}, 12'h000);
      #2 RESETN = 1'b1;
      idle(20);

      // 0xA5 with READY=1
      r0 = rise_cnt; h0 = hi_cnt; c0 = cyc;
      send(8'hA5, 1'b1, 1'b0);
      idle(20);
      check("a5_valid_count", 12'(rise_cnt - r0), 12'd1);
      check("a5_data", {4'h0, rise_data}, 12'h0A5);
      check("a5_valid_width", 12'(hi_cnt - h0), 12'd1);
      lat = rise_cyc - c0;
      vectors++;
      if (lat < 975 || lat > 987) begin
         miscompares++;
         $display("FAIL a5_latency: got %0d cycles, want 975..987", lat);
      end

      // 20-cycle low glitch
      r0 = rise_cnt; f0 = ferr_cnt;
      bus.RX = 1'b0;
      idle(10);
      check("glitch_busy_high", {11'h0, bus.BUSY}, 12'd1);
      idle(10);
      bus.RX = 1'b1;
      idle(100);
      check("glitch_busy_low", {11'h0, bus.BUSY}, 12'd0);
      check("glitch_no_valid", 12'(rise_cnt - r0), 12'd0);
      check("glitch_no_ferr", 12'(ferr_cnt - f0), 12'd0);

      // 0x3C with a low stop bit, then 0x81
      r0 = rise_cnt; f0 = ferr_cnt;
      send(8'h3C, 1'b0, 1'b0);
      bus.RX = 1'b1;
      idle(20);
      check("ferr_count", 12'(ferr_cnt - f0), 12'd1);
      check("ferr_no_valid", 12'(rise_cnt - r0), 12'd0);
      check("ferr_valid_low", {11'h0, bus.VALID}, 12'd0);
      send(8'h81, 1'b1, 1'b0);
      idle(20);
      check("after_ferr_count", 12'(rise_cnt - r0), 12'd1);
      check("after_ferr_data", {4'h0, rise_data}, 12'h081);

      // back-to-back 0x11 / 0x22 with READY low
      o0 = ovr_cnt;
      bus.READY = 1'b0;
      send(8'h11, 1'b1, 1'b0);
      send(8'h22, 1'b1, 1'b0);
      idle(20);
      check("ovr_valid_held", {11'h0, bus.VALID}, 12'd1);
      check("ovr_data_held", {4'h0, bus.DATA}, 12'h011);
      check("ovr_count", 12'(ovr_cnt - o0), 12'd1);
      bus.READY = 1'b1;
      idle(1);
      check("ovr_valid_drop", {11'h0, bus.VALID}, 12'd0);
      idle(20);

      // reset during bit 4 of 0xFF, then 0x5A
      r0 = rise_cnt;
      drive_bit(1'b0);
      for (int i = 0; i < 4; i++) drive_bit(1'b1);
      idle(D / 2);
      #2 RESETN = 1'b0;
      idle(2);
      check("midframe_reset_outputs",
            {bus.BUSY, bus.VALID, bus.FRAME_ERR, bus.OVERRUN, bus.DATA}, 12'h000);
      #2 RESETN = 1'b1;
      idle(D * 5);
      check("midframe_no_valid", 12'(rise_cnt - r0), 12'd0);
      send(8'h5A, 1'b1, 1'b0);
      idle(20);
      check("post_reset_count", 12'(rise_cnt - r0), 12'd1);
      check("post_reset_data", {4'h0, rise_data}, 12'h05A);

`ifdef UART_RX_PARITY_EN
      r0 = rise_cnt; f0 = ferr_cnt;
      send(8'h07, 1'b1, 1'b0);
      idle(20);
      check("parity_good_data", {4'h0, rise_data}, 12'h007);
      check("parity_good_count", 12'(rise_cnt - r0), 12'd1);
      r0 = rise_cnt;
      send(8'h07, 1'b1, 1'b1);
      idle(20);
      check("parity_bad_ferr", 12'(ferr_cnt - f0), 12'd1);
      check("parity_bad_no_valid", 12'(rise_cnt - r0), 12'd0);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 SHALL have parameter DIVISOR, default 103, clock cycles per bit (12 MHz / 103 ≈ 115200 baud); legal range 4..255.
REQ-002 SHALL have port CLK, input, 1, single clock; all state on its rising edge.
REQ-003 SHALL have port RESETN, input, 1; reset is asynchronous and active-low.
REQ-004 SHALL have port RX, input, 1, serial line, idle high, asynchronous to CLK.
REQ-005 SHALL have port READY, input, 1, consumer accepts DATA when high with VALID.
REQ-006 SHALL have port DATA, output, 8, received byte.
REQ-007 SHALL have port VALID, output, 1, DATA holds an unconsumed byte.
REQ-008 SHALL have port FRAME_ERR, output, 1, one-cycle pulse on a bad stop bit.
REQ-009 SHALL have port OVERRUN, output, 1, one-cycle pulse when a completed byte is dropped.
REQ-010 SHALL have port BUSY, output, 1, high in every state except IDLE.

Function
REQ-011 SHALL pass RX through a 2-flop synchronizer, preset high; all decisions use the synchronized value.
REQ-012 SHALL implement states IDLE, START, DATA, STOP.
REQ-013 IDLE: a synchronized 1->0 transition SHALL load the bit timer with DIVISOR/2 (truncating) and enter START.
REQ-014 START: on timer expiry, sample RX; low -> load timer with DIVISOR, clear the bit counter, enter DATA; high -> glitch, return to IDLE with no output pulse.
REQ-015 DATA: on each timer expiry, shift the sampled bit in LSB-first and reload DIVISOR; after the 8th sample enter STOP.
REQ-016 STOP: on timer expiry, sample RX, then return to IDLE in the same cycle; the next start edge is accepted on the following cycle.
REQ-017 Stop sample high with VALID low or being consumed this cycle SHALL load DATA and set VALID on the next edge.
REQ-018 Stop sample high while VALID is high and READY is low SHALL pulse OVERRUN and leave DATA/VALID unchanged.
REQ-019 Stop sample low SHALL pulse FRAME_ERR, SHALL NOT load DATA or change VALID, and new-start detection SHALL wait for RX to return high (edge rule).
REQ-020 VALID SHALL clear on the cycle after VALID&READY, unless REQ-017 reloads it in the same cycle, in which case it stays high with the new byte.
REQ-021 DATA SHALL be stable while VALID is high.
REQ-022 Timer and bit counter SHALL be sized for 255 and 8 without wrap-around; timer expiry = count reaches 1 after load.

Reset
REQ-023 RESETN low SHALL immediately force IDLE, synchronizer flops = 1, timer = 0, bit counter = 0, DATA = 0x00, VALID = 0, FRAME_ERR = 0, OVERRUN = 0, BUSY = 0.
REQ-024 Reset mid-frame SHALL discard the partial byte; after release a new frame SHALL be received only from a fresh start edge.
REQ-025 RESETN deassertion SHALL be synchronized externally; the block SHALL use it as an asynchronous clear only.

Configuration
REQ-026 Macro UART_RX_PARITY_EN defined: an even-parity bit is sampled after bit 7 (state PARITY, one bit time, between DATA and STOP); mismatch with the stop bit high SHALL pulse FRAME_ERR and drop the byte.
REQ-027 Macro UART_RX_PARITY_EN undefined: no PARITY state; frame is 8N1 (10 bit times).

Verification
REQ-028 Reset, then send 8N1 byte 0xA5 at DIVISOR=103 with READY=1 -> VALID high for 1 cycle, DATA=0xA5, about 9.5*103 cycles after the start edge.
REQ-029 Low glitch of 20 cycles on RX -> return to IDLE, BUSY low afterwards, no VALID/FRAME_ERR.
REQ-030 Send 0x3C with stop bit held low -> FRAME_ERR one pulse, VALID stays 0; then 0x81 after RX goes high -> DATA=0x81.
REQ-031 READY=0, send 0x11 then 0x22 back-to-back -> DATA=0x11 held, OVERRUN one pulse at 0x22's stop sample; READY=1 -> VALID drops next cycle.
REQ-032 RESETN pulsed low during bit 4 of 0xFF, then 0x5A sent -> only 0x5A delivered, all outputs at reset values during reset.
REQ-033 With UART_RX_PARITY_EN: 0x07 with parity 1 -> DATA=0x07; with parity 0 -> FRAME_ERR, no VALID.
